pin_walk_checker: RTL
=====================

# pin_walk_checker

Receive-side companion to the walking-one pin driver. It samples an externally looped-back or probed `NUM_PINS` bus and synchronizes it into `clk_i`. It then verifies that the bus carries a one-hot pattern stepping upward by one index every `CLOCK_FREQ_HZ / DIVISOR` cycles, wrapping from `NUM_PINS-1` to 0. Once a full walk is verified it reports lock, the current index, and classified error pulses with a saturating error count. It is used on board bring-up to validate pin wiring and headers.

## Interface
- `NUM_PINS`, 8, width of the monitored bus (≥2).
- `CLOCK_FREQ_HZ`, 100_000_000, `clk_i` frequency.
- `DIVISOR`, 4, expected step rate; `DELAY = CLOCK_FREQ_HZ / DIVISOR` cycles per pin.
- `TOLERANCE`, 16, allowed ± deviation of each dwell, in cycles (< `DELAY`).
- `ERR_COUNT_WIDTH`, 16, width of the error counter.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `pins_i`  in  `NUM_PINS`  asynchronous monitored bus.
- `idx_o`  out  `$clog2(NUM_PINS)`  index of the last valid one-hot sample.
- `valid_o`  out  1  current synchronized sample is exactly one-hot.
- `locked_o`  out  1  a full walk has been verified and no error has occurred since.
- `err_o`  out  1  one-cycle error pulse; only raised while locked.
- `err_code_o`  out  2  cause of the error: 1 = not one-hot, 2 = bad sequence, 3 = dwell out of window; holds its value until the next error.
- `err_count_o`  out  `ERR_COUNT_WIDTH`  errors since reset; saturates at all-ones.

## Operation
- **Synchronizer:** two flops per pin (`sync1`, `sync2`), then a `prev` register. `s = sync2`.
- **Transition:** a transition is any cycle where `s != prev`.
- **Dwell counter:**
  - Width `$clog2(DELAY+TOLERANCE+2)`.
  - On a transition it loads 1; otherwise it increments, saturating at `DELAY+TOLERANCE+1`.
  - At a transition, the pre-update value is the dwell of the old value. A pin held exactly N cycles yields dwell N.
- **Window:** a dwell is good if `DELAY-TOLERANCE ≤ dwell ≤ DELAY+TOLERANCE`.
- **Step:** a step is good if the new sample is one-hot and `new_idx == (last_idx+1) mod NUM_PINS`.
- **State machine:** states are HUNT, ACQUIRE, LOCKED, with `match` counter 0..`NUM_PINS`.
  - **HUNT:** on a transition to a one-hot value, record its index, set `match=0`, go to ACQUIRE. The first dwell is never judged, because entry happens mid-dwell.
  - **ACQUIRE:**
    - On a transition with a good step and good dwell: `match++`. When `match` reaches `NUM_PINS`, go to LOCKED and assert `locked_o` from the next cycle.
    - On a transition to a one-hot value that fails the step or dwell check: restart ACQUIRE from the new index.
    - On a non-one-hot sample: go to HUNT.
    - No errors are reported in this state.
  - **LOCKED:** check every cycle, in priority order 1 > 2 > 3 (only the highest-priority cause is reported):
    1. `s` is not one-hot → code 1.
    2. Transition with a bad step → code 2.
    3. Transition with a bad dwell, or the dwell counter reaches `DELAY+TOLERANCE+1` with no transition (timeout) → code 3.
  - **On any LOCKED error:**
    - Pulse `err_o`.
    - Load `err_code_o`.
    - Increment `err_count_o` (saturating).
    - Clear `locked_o`.
    - Go to HUNT.
- **`idx_o`:** updates with the index of the set bit whenever the sample is one-hot; holds otherwise.
- **`valid_o`:** registered one-hot flag of `s`.

## Timing
- **Reset:**
  - All outputs are 0 after the clock edge with `rst_i` high.
  - Synchronizer, `prev`, dwell counter, `match` and `err_count` are cleared; state is HUNT.
  - Reset mid-operation behaves identically and clears the error count.
- **Latency:** a `pins_i` change is visible on `idx_o` / `valid_o` 3 cycles later (2 sync + 1 register).
- **Error latency:** `err_o` asserts in the same cycle those outputs reflect the offending sample. A timeout asserts `err_o` one cycle after the dwell counter reaches the limit.
- **Error spacing:** errors are at most one per cycle. Back-to-back errors cannot occur, because HUNT and ACQUIRE suppress reporting.
- **Saturation:** an error that occurs while the count is saturated still pulses `err_o` and updates `err_code_o`.
- **Idle bus:** an all-zero bus never leaves HUNT.
- **Relock:** relocking requires `NUM_PINS` good steps after the first transition out of HUNT.

## Test plan
Parameters for all tests: `NUM_PINS=4`, `CLOCK_FREQ_HZ=40`, `DIVISOR=4` (`DELAY=10`), `TOLERANCE=2`, `ERR_COUNT_WIDTH=2`.

1. **Clean walk:** ideal walk of 10 cycles per pin (0001→0010→0100→1000→0001…) from reset → `locked_o` rises after the first transition plus 4 good steps. `idx_o` follows 0,1,2,3,0 with 3-cycle lag. `err_o` never fires; `err_count_o=0`.
2. **Not one-hot:** while locked, drive 0101 for one cycle → one `err_o` pulse, `err_code_o=1`, `err_count_o=1`, `locked_o=0`. Relock after 4 further good steps.
3. **Bad sequence:** while locked, step 0010→1000 (index 1→3) → `err_code_o=2`.
4. **Dwell boundaries:**
   - Dwells of 8 and 12 → no error.
   - A dwell of 7 → `err_code_o=3`.
   - Holding one pin 13+ cycles → `err_code_o=3` via timeout, before any transition.
5. **Counter saturation:** cause 5 locked errors, relocking between each → `err_count_o` reads 1, 2, 3, 3, 3. The pulse still fires on every error.
6. **Reset mid-lock:** assert `rst_i` for 1 cycle while locked → all outputs 0 the next cycle. Relock occurs exactly as in scenario 1.

Source files
------------

// File: rtl/pin_walk_checker.sv
`default_nettype none
// ============================================================================
// Module      : pin_walk_checker
// Description : Verifies that a synchronized bus walks a one-hot pattern with
//               a fixed dwell; reports lock, index and classified errors.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_walk_checker #(
    parameter int NUM_PINS        = 8,
    parameter int CLOCK_FREQ_HZ   = 100_000_000,
    parameter int DIVISOR         = 4,
    parameter int TOLERANCE       = 16,
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_PINS-1:0]         pins_i,
    output logic [$clog2(NUM_PINS)-1:0] idx_o,
    output logic                        valid_o,
    output logic                        locked_o,
    output logic                        err_o,
    output logic [1:0]                  err_code_o,
    output logic [ERR_COUNT_WIDTH-1:0]  err_count_o
);

    localparam int c_idx_w   = $clog2(NUM_PINS);
    localparam int c_delay   = CLOCK_FREQ_HZ / DIVISOR;
    localparam int c_cnt_w   = $clog2(c_delay + TOLERANCE + 2);
    localparam int c_match_w = $clog2(NUM_PINS + 1);

    localparam logic [c_cnt_w-1:0]   c_cnt_one  = 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_lim  = c_cnt_w'(c_delay + TOLERANCE + 1);
    localparam logic [c_cnt_w-1:0]   c_win_lo   = c_cnt_w'(c_delay - TOLERANCE);
    localparam logic [c_cnt_w-1:0]   c_win_hi   = c_cnt_w'(c_delay + TOLERANCE);
    localparam logic [c_idx_w-1:0]   c_idx_one  = 1;
    localparam logic [c_idx_w-1:0]   c_idx_top  = c_idx_w'(NUM_PINS - 1);
    localparam logic [c_match_w-1:0] c_match_one  = 1;
    localparam logic [c_match_w-1:0] c_match_last = c_match_w'(NUM_PINS - 1);
    localparam logic [ERR_COUNT_WIDTH-1:0] c_err_one = 1;

    localparam logic [1:0] c_code_not_onehot = 2'd1;
    localparam logic [1:0] c_code_bad_step   = 2'd2;
    localparam logic [1:0] c_code_bad_dwell  = 2'd3;

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    logic [NUM_PINS-1:0]        r_sync1;
    logic [NUM_PINS-1:0]        r_sync2;
    logic [NUM_PINS-1:0]        r_prev;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [c_match_w-1:0]       r_match;
    state_t                     r_state;
    logic [c_idx_w-1:0]         r_idx;
    logic                       r_valid;
    logic                       r_locked;
    logic                       r_err;
    logic [1:0]                 r_code;
    logic [ERR_COUNT_WIDTH-1:0] r_count;

    logic                 w_trans;
    logic                 w_onehot;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_idx_w-1:0]   w_idx_expect;
    logic                 w_step_ok;
    logic                 w_dwell_ok;
    logic                 w_timeout;
    state_t               w_state_nxt;
    logic [c_match_w-1:0] w_match_nxt;
    logic                 w_err_nxt;
    logic [1:0]           w_code_nxt;

    assign w_trans  = (r_sync2 != r_prev);
    assign w_onehot = $onehot(r_sync2);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (r_sync2[i]) begin
                w_idx = c_idx_w'(i);
            end
        end
    end

    // r_idx always holds the most recent one-hot index, i.e. the previous step
    assign w_idx_expect = (r_idx == c_idx_top) ? '0 : r_idx + c_idx_one;
    assign w_step_ok    = w_onehot && (w_idx == w_idx_expect);
    assign w_dwell_ok   = (r_cnt >= c_win_lo) && (r_cnt <= c_win_hi);
    assign w_timeout    = !w_trans && (r_cnt == c_cnt_lim);

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_err_nxt   = 1'b0;
        w_code_nxt  = 2'd0;
        case (r_state)
            S_HUNT: begin
                if (w_trans && w_onehot) begin
                    w_state_nxt = S_ACQUIRE;
                    w_match_nxt = '0;
                end
            end
            S_ACQUIRE: begin
                if (!w_onehot) begin
                    w_state_nxt = S_HUNT;
                end else if (w_trans) begin
                    if (w_step_ok && w_dwell_ok) begin
                        w_match_nxt = r_match + c_match_one;
                        if (r_match == c_match_last) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (!w_onehot) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = c_code_not_onehot;
                end else if (w_trans && !w_step_ok) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = c_code_bad_step;
                end else if ((w_trans && !w_dwell_ok) || w_timeout) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = c_code_bad_dwell;
                end
                if (w_err_nxt) begin
                    w_state_nxt = S_HUNT;
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
            r_match  <= '0;
            r_state  <= S_HUNT;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= 2'd0;
            r_count  <= '0;
        end else begin
            r_sync1 <= pins_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_trans) begin
                r_cnt <= c_cnt_one;
            end else if (r_cnt != c_cnt_lim) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            r_state  <= w_state_nxt;
            r_match  <= w_match_nxt;
            r_valid  <= w_onehot;
            if (w_onehot) begin
                r_idx <= w_idx;
            end
            r_locked <= (w_state_nxt == S_LOCKED);
            r_err    <= w_err_nxt;
            if (w_err_nxt) begin
                r_code <= w_code_nxt;
                if (r_count != '1) begin
                    r_count <= r_count + c_err_one;
                end
            end
        end
    end

    assign idx_o       = r_idx;
    assign valid_o     = r_valid;
    assign locked_o    = r_locked;
    assign err_o       = r_err;
    assign err_code_o  = r_code;
    assign err_count_o = r_count;

endmodule
`default_nettype wire
